// File: rtl/dsp_spi_slave.sv
// ---------------------------------------------------------------------------
// dsp_spi_slave
// SPI mode-0 responder giving the C6678 DSP register access into the EVM
// FPGA.  All SPI pins are oversampled in the 48 MHz domain.  Each 16-bit frame
// (command byte {R/nW, addr[6:0]}, then data byte) is decoded into one-cycle
// register read/write strobes.
//
// Optional feature: define DSP_SPI_STATUS_EN to shift a status byte
// {STATUS_ID, err_cnt[4:0]} out on MISO during the command byte.  Without
// it, MISO is 0 during the command byte and no error counter exists.
//
// Ports:
//   main_48mhz_clk_r_i  48 MHz clock
//   fpga_rstn           async active-low reset
//   dsp_sspcs1_i        SPI chip select (active low)
//   dsp_sspck_i         SPI clock (mode 0)
//   dsp_sspmosi_i       serial data in, MSB first
//   dsp_sspmiso_o       serial data out
//   dsp_sspmiso_oe_o    MISO output enable (CS active)
//   reg_addr_o          register address, held between frames
//   reg_wdata_o         write data, valid with reg_wr_o
//   reg_wr_o            one-cycle write strobe
//   reg_rd_o            one-cycle read strobe
//   reg_rdata_i         read data, sampled one cycle after reg_rd_o
//   frame_err_o         one-cycle pulse on aborted/malformed frame
// ---------------------------------------------------------------------------
module dsp_spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] STATUS_ID   = 3'b101
) (
    input  logic       main_48mhz_clk_r_i,
    input  logic       fpga_rstn,
    input  logic       dsp_sspcs1_i,
    input  logic       dsp_sspck_i,
    input  logic       dsp_sspmosi_i,
    output logic       dsp_sspmiso_o,
    output logic       dsp_sspmiso_oe_o,
    output logic [6:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_wr_o,
    output logic       reg_rd_o,
    input  logic [7:0] reg_rdata_i,
    output logic       frame_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Saturating 5-bit increment for the error counter.
    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : (v + 5'd1);
    endfunction

    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sck_prev_r;
    logic [SYNC_STAGES:0]   flush_r;

    logic cs_s;
    logic sck_s;
    logic mosi_s;
    logic sck_rise_s;
    logic sck_fall_s;
    logic [7:0] status_s;

    state_t     state_r;
    logic [4:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic [7:0] miso_sh_r;
    logic [7:0] rdata_r;
    logic       rnw_r;
    logic       invalid_r;
    logic       armed_r;
    logic       rd_d1_r;

    // Input synchronizers; flush_r marks when the chains hold real pin values.
    always_ff @(posedge main_48mhz_clk_r_i or negedge fpga_rstn) begin
        if (!fpga_rstn) begin
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            sck_sync_r  <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sck_prev_r  <= 1'b0;
            flush_r     <= {(SYNC_STAGES+1){1'b0}};
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], dsp_sspcs1_i};
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], dsp_sspck_i};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], dsp_sspmosi_i};
            sck_prev_r  <= sck_sync_r[SYNC_STAGES-1];
            flush_r     <= {flush_r[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_s       = cs_sync_r[SYNC_STAGES-1];
    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_prev_r;
    assign sck_fall_s = ~sck_s & sck_prev_r;

`ifdef DSP_SPI_STATUS_EN
    logic [4:0] err_cnt_r;

    // Saturating count of frame_err_o pulses, reported in the status byte.
    always_ff @(posedge main_48mhz_clk_r_i or negedge fpga_rstn) begin
        if (!fpga_rstn) begin
            err_cnt_r <= 5'd0;
        end else if (frame_err_o) begin
            err_cnt_r <= sat_inc5(err_cnt_r);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign status_s = {STATUS_ID, err_cnt_r};
`else
    // Status reporting not built: command-byte MISO is all zeros.
    assign status_s = {STATUS_ID, sat_inc5(5'd0)} & 8'h00;
`endif

    // Frame FSM: bit counting, register strobes and MISO shifting.
    always_ff @(posedge main_48mhz_clk_r_i or negedge fpga_rstn) begin
        if (!fpga_rstn) begin
            state_r          <= ST_IDLE;
            bit_cnt_r        <= 5'd0;
            shift_r          <= 8'h00;
            miso_sh_r        <= 8'h00;
            rdata_r          <= 8'h00;
            rnw_r            <= 1'b0;
            invalid_r        <= 1'b0;
            armed_r          <= 1'b0;
            rd_d1_r          <= 1'b0;
            dsp_sspmiso_o    <= 1'b0;
            dsp_sspmiso_oe_o <= 1'b0;
            reg_addr_o       <= 7'h00;
            reg_wdata_o      <= 8'h00;
            reg_wr_o         <= 1'b0;
            reg_rd_o         <= 1'b0;
            frame_err_o      <= 1'b0;
        end else begin
            reg_wr_o         <= 1'b0;
            reg_rd_o         <= 1'b0;
            frame_err_o      <= 1'b0;
            rd_d1_r          <= reg_rd_o;
            dsp_sspmiso_oe_o <= ~cs_s;
            if (rd_d1_r) begin
                rdata_r <= reg_rdata_i;
            end
            // A frame already running when reset released is ignored: only
            // start accepting once CS has been seen high on real pin data.
            if (flush_r[SYNC_STAGES] && cs_s) begin
                armed_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    dsp_sspmiso_o <= 1'b0;
                    if (armed_r && !cs_s) begin
                        bit_cnt_r     <= 5'd0;
                        invalid_r     <= 1'b0;
                        // MSB must be on the wire before the first SCK rise.
                        dsp_sspmiso_o <= status_s[7];
                        miso_sh_r     <= {status_s[6:0], 1'b0};
                        state_r       <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    if (cs_s) begin
                        frame_err_o   <= 1'b1;
                        dsp_sspmiso_o <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        if (sck_rise_s) begin
                            shift_r   <= {shift_r[6:0], mosi_s};
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                            if (bit_cnt_r == 5'd7) begin
                                reg_addr_o <= {shift_r[5:0], mosi_s};
                                rnw_r      <= shift_r[6];
                                reg_rd_o   <= shift_r[6];
                                state_r    <= ST_DATA;
                            end
                        end
                        if (sck_fall_s) begin
                            dsp_sspmiso_o <= miso_sh_r[7];
                            miso_sh_r     <= {miso_sh_r[6:0], 1'b0};
                        end
                    end
                end

                ST_DATA: begin
                    if (cs_s) begin
                        frame_err_o   <= 1'b1;
                        dsp_sspmiso_o <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        if (sck_rise_s) begin
                            shift_r   <= {shift_r[6:0], mosi_s};
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                            if (bit_cnt_r == 5'd15) begin
                                state_r <= ST_DONE;
                            end
                        end
                        if (sck_fall_s) begin
                            if (!rnw_r) begin
                                dsp_sspmiso_o <= 1'b0;
                            end else if (bit_cnt_r == 5'd8) begin
                                // rdata was captured well before this fall.
                                dsp_sspmiso_o <= rdata_r[7];
                                miso_sh_r     <= {rdata_r[6:0], 1'b0};
                            end else begin
                                dsp_sspmiso_o <= miso_sh_r[7];
                                miso_sh_r     <= {miso_sh_r[6:0], 1'b0};
                            end
                        end
                    end
                end

                ST_DONE: begin
                    if (cs_s) begin
                        if (invalid_r) begin
                            frame_err_o <= 1'b1;
                        end else if (!rnw_r) begin
                            reg_wdata_o <= shift_r;
                            reg_wr_o    <= 1'b1;
                        end
                        dsp_sspmiso_o <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        // A 17th bit makes the whole frame invalid.
                        if (sck_rise_s) begin
                            invalid_r <= 1'b1;
                        end
                        if (sck_fall_s) begin
                            dsp_sspmiso_o <= 1'b0;
                        end
                    end
                end

                default: begin
                    dsp_sspmiso_o <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_spi_slave.sv
`timescale 1ns/1ps
module tb_dsp_spi_slave;

    logic       clk = 1'b0;
    logic       fpga_rstn;
    logic       cs;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       frame_err;

    always #10 clk = ~clk;

    dsp_spi_slave dut (
        .main_48mhz_clk_r_i (clk),
        .fpga_rstn          (fpga_rstn),
        .dsp_sspcs1_i       (cs),
        .dsp_sspck_i        (sck),
        .dsp_sspmosi_i      (mosi),
        .dsp_sspmiso_o      (miso),
        .dsp_sspmiso_oe_o   (miso_oe),
        .reg_addr_o         (reg_addr),
        .reg_wdata_o        (reg_wdata),
        .reg_wr_o           (reg_wr),
        .reg_rd_o           (reg_rd),
        .reg_rdata_i        (reg_rdata),
        .frame_err_o        (frame_err)
    );

`ifdef DSP_SPI_STATUS_EN
    localparam logic [7:0] STAT_ZERO = 8'hA0;
    localparam logic [7:0] STAT_TWO  = 8'hA2;
`else
    localparam logic [7:0] STAT_ZERO = 8'h00;
    localparam logic [7:0] STAT_TWO  = 8'h00;
`endif

    int checks   = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected strobes queued by stimulus, popped on DUT strobes.
    logic [14:0] wr_q[$];
    logic [6:0]  rd_q[$];
    logic [14:0] exp_wr;
    logic [6:0]  exp_rd;
    int wr_seen  = 0;
    int rd_seen  = 0;
    int err_seen = 0;

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_seen++;
            check_value("wr_expected", 32'(wr_q.size() > 0), 32'd1);
            if (wr_q.size() > 0) begin
                exp_wr = wr_q.pop_front();
                check_value("wr_addr", 32'(reg_addr), 32'(exp_wr[14:8]));
                check_value("wr_data", 32'(reg_wdata), 32'(exp_wr[7:0]));
            end
        end
        if (reg_rd) begin
            rd_seen++;
            check_value("rd_expected", 32'(rd_q.size() > 0), 32'd1);
            if (rd_q.size() > 0) begin
                exp_rd = rd_q.pop_front();
                check_value("rd_addr", 32'(reg_addr), 32'(exp_rd));
            end
        end
        if (frame_err) begin
            err_seen++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_miso"},  32'(miso),      32'd0);
        check_value({tag, "_oe"},    32'(miso_oe),   32'd0);
        check_value({tag, "_addr"},  32'(reg_addr),  32'd0);
        check_value({tag, "_wdata"}, 32'(reg_wdata), 32'd0);
        check_value({tag, "_wr"},    32'(reg_wr),    32'd0);
        check_value({tag, "_rd"},    32'(reg_rd),    32'd0);
        check_value({tag, "_err"},   32'(frame_err), 32'd0);
    endtask

    // One SPI frame at 6 MHz (4 clocks per SCK half period); MISO is sampled
    // at each SCK rise as the DSP would.  rst_bit >= 0 pulses reset there.
    task automatic spi_xfer(input int nbits, input logic [31:0] bits, input int rst_bit,
                            input int gap, output logic [31:0] miso_bits);
        miso_bits = 32'd0;
        cs = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                fpga_rstn = 1'b0;
                wait_clk(2);
                check_reset_outputs("midrst");
                fpga_rstn = 1'b1;
                wait_clk(1);
            end
            mosi = bits[nbits-1-i];
            wait_clk(4);
            sck = 1'b1;
            miso_bits = {miso_bits[30:0], miso};
            wait_clk(4);
            sck = 1'b0;
        end
        wait_clk(4);
        cs   = 1'b1;
        mosi = 1'b0;
        wait_clk(gap);
    endtask

    logic [31:0] mb;
    int w0, r0, e0;

    task automatic snap();
        w0 = wr_seen;
        r0 = rd_seen;
        e0 = err_seen;
    endtask

    task automatic check_deltas(input string tag, input int dw, input int dr, input int de);
        wait_clk(6);
        check_value({tag, "_wr_cnt"},  32'(wr_seen - w0),  32'(dw));
        check_value({tag, "_rd_cnt"},  32'(rd_seen - r0),  32'(dr));
        check_value({tag, "_err_cnt"}, 32'(err_seen - e0), 32'(de));
    endtask

    initial begin
        fpga_rstn = 1'b0;
        cs        = 1'b1;
        sck       = 1'b0;
        mosi      = 1'b0;
        reg_rdata = 8'h00;
        wait_clk(3);
        check_reset_outputs("reset");
        fpga_rstn = 1'b1;
        wait_clk(8);

        // Plain write 0x05 <- 0x3C
        snap();
        wr_q.push_back({7'h05, 8'h3C});
        spi_xfer(16, 32'h053C, -1, 8, mb);
        check_deltas("write1", 1, 0, 0);
        check_value("addr_hold", 32'(reg_addr), 32'h05);
        check_value("wdata_hold", 32'(reg_wdata), 32'h3C);

        // Read 0x05 returning 0xA7; command byte shows status with no errors
        snap();
        reg_rdata = 8'hA7;
        rd_q.push_back(7'h05);
        spi_xfer(16, 32'h8500, -1, 8, mb);
        check_deltas("read1", 0, 1, 0);
        check_value("read1_miso_data", 32'(mb[7:0]), 32'hA7);
        check_value("read1_miso_cmd", 32'(mb[15:8]), 32'(STAT_ZERO));

        // Write aborted after 12 bits
        snap();
        spi_xfer(12, 32'h0A5, -1, 8, mb);
        check_deltas("abort12", 0, 0, 1);

        // Next valid write is accepted
        snap();
        wr_q.push_back({7'h12, 8'h5A});
        spi_xfer(16, 32'h125A, -1, 8, mb);
        check_deltas("write2", 1, 0, 0);

        // 17-bit write: {0x0C, 0xE7, 1}
        snap();
        spi_xfer(17, 32'h19CF, -1, 8, mb);
        check_deltas("bits17", 0, 0, 1);

        // Read after two aborted frames
        snap();
        reg_rdata = 8'h3E;
        rd_q.push_back(7'h01);
        spi_xfer(16, 32'h8100, -1, 8, mb);
        check_deltas("read2", 0, 1, 0);
        check_value("read2_miso_data", 32'(mb[7:0]), 32'h3E);
        check_value("read2_miso_cmd", 32'(mb[15:8]), 32'(STAT_TWO));

        // Reset during the data byte of a write: no strobe at all
        snap();
        spi_xfer(16, 32'h07FF, 11, 8, mb);
        check_deltas("midrst", 0, 0, 0);

        // Next full frame after reset writes correctly
        snap();
        wr_q.push_back({7'h07, 8'h11});
        spi_xfer(16, 32'h0711, -1, 8, mb);
        check_deltas("write3", 1, 0, 0);

        // Error count cleared by reset
        snap();
        reg_rdata = 8'h5C;
        rd_q.push_back(7'h00);
        spi_xfer(16, 32'h8000, -1, 8, mb);
        check_deltas("read3", 0, 1, 0);
        check_value("read3_miso_data", 32'(mb[7:0]), 32'h5C);
        check_value("read3_miso_cmd", 32'(mb[15:8]), 32'(STAT_ZERO));

        // Back-to-back writes with a short CS-high gap
        snap();
        wr_q.push_back({7'h21, 8'hC3});
        wr_q.push_back({7'h22, 8'h3C});
        spi_xfer(16, 32'h21C3, -1, 1, mb);
        spi_xfer(16, 32'h223C, -1, 8, mb);
        check_deltas("b2b", 2, 0, 0);

        check_value("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check_value("rd_q_empty", 32'(rd_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
